// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (consumed by imem_dmem_arbiter).
package imem_dmem_arbiter_pkg;

    // Existing bus widths of the minimal SOPC.
    localparam int unsigned InstAddrBus   = 32;
    localparam int unsigned InstBus       = 32;

    // Default extra memory latency beyond one cycle.
    localparam int unsigned ArbWaitCycles = 0;

    typedef enum logic {
        ArbIdle = 1'b0,
        ArbBusy = 1'b1
    } arb_state_t;

    typedef enum logic {
        OwnerInst = 1'b0,
        OwnerData = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/imem_dmem_arbiter_wait_cnt.sv
// Loadable down-counter that sequences memory wait states.
// Stops at zero; zero_o flags the access completion cycle.
module arb_wait_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over counting; counting saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (en_i && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_o = (cnt == '0);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch
// and load/store ports: arbitration, wait-state sequencing, response steering
// and pipeline stall request.
// Optional build macro: ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// instead of fixed data-over-inst priority.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = InstAddrBus,
    parameter int unsigned DATA_W      = InstBus,
    parameter int unsigned WAIT_CYCLES = ArbWaitCycles,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req_i,
    input  logic [ADDR_W-1:0]   inst_addr_i,
    output logic                inst_gnt_o,
    output logic                inst_rvalid_o,
    output logic [DATA_W-1:0]   inst_rdata_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W/8-1:0] data_sel_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                stall_req_o
);

    arb_state_t state;
    arb_state_t state_nxt;
    arb_owner_t owner;
    logic       owner_store;
    logic       cnt_zero;
    logic       grant_win;
    logic       gnt_any;
    logic       resp;
    logic       data_first;

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t last_gnt;

    // Remember which port was granted last; starts as "inst" so data wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= OwnerInst;
        end else if (gnt_any) begin
            last_gnt <= data_gnt_o ? OwnerData : OwnerInst;
        end
    end

    assign data_first = (last_gnt == OwnerInst);
`else
    assign data_first = 1'b1;
`endif

    arb_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (gnt_any),
        .load_val_i (CNT_W'(WAIT_CYCLES)),
        .en_i       (state == ArbBusy),
        .zero_o     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ArbIdle;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture who owns the outstanding access and whether it is a store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner       <= OwnerInst;
            owner_store <= 1'b0;
        end else if (gnt_any) begin
            owner       <= data_gnt_o ? OwnerData : OwnerInst;
            owner_store <= data_gnt_o & data_we_i;
        end
    end

    // Arbitration, memory strobe, response steering, stall and next state.
    // Combinational paths from the request inputs are gated by rst so every
    // output reads 0 while reset is asserted.
    always_comb begin
        state_nxt     = state;
        grant_win     = rst & ((state == ArbIdle) | cnt_zero);
        resp          = rst & (state == ArbBusy) & cnt_zero;
        data_gnt_o    = grant_win & data_req_i & (data_first | ~inst_req_i);
        inst_gnt_o    = grant_win & inst_req_i & ~data_gnt_o;
        gnt_any       = data_gnt_o | inst_gnt_o;
        mem_ce_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_sel_o     = '0;
        mem_wdata_o   = '0;

        if (data_gnt_o) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = data_we_i;
            mem_addr_o  = data_addr_i;
            mem_sel_o   = data_sel_i;
            mem_wdata_o = data_wdata_i;
        end else if (inst_gnt_o) begin
            mem_ce_o    = 1'b1;
            mem_addr_o  = inst_addr_i;
            mem_sel_o   = '1;
        end

        inst_rvalid_o = resp & (owner == OwnerInst);
        data_rvalid_o = resp & (owner == OwnerData);
        inst_rdata_o  = inst_rvalid_o ? mem_rdata_i : '0;
        data_rdata_o  = (data_rvalid_o & ~owner_store) ? mem_rdata_i : '0;

        stall_req_o   = rst & ((inst_req_i & ~inst_gnt_o) |
                               (data_req_i & ~data_gnt_o) |
                               ((state == ArbBusy) & ~cnt_zero));

        if (gnt_any) begin
            state_nxt = ArbBusy;
        end else if (resp) begin
            state_nxt = ArbIdle;
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed sequences plus random
// traffic, checked against a cycle-count based reference model and a
// reference memory image.
module tb_imem_dmem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned WAIT = 2;
    localparam int unsigned MEMW = 256;

    logic          clk;
    logic          rst;
    logic          inst_req_i;
    logic [AW-1:0] inst_addr_i;
    logic          inst_gnt_o;
    logic          inst_rvalid_o;
    logic [DW-1:0] inst_rdata_o;
    logic          data_req_i;
    logic          data_we_i;
    logic [AW-1:0] data_addr_i;
    logic [SW-1:0] data_sel_i;
    logic [DW-1:0] data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_ce_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [SW-1:0] mem_sel_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          stall_req_o;

    imem_dmem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_CYCLES (WAIT),
        .CNT_W       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req_i    (inst_req_i),
        .inst_addr_i   (inst_addr_i),
        .inst_gnt_o    (inst_gnt_o),
        .inst_rvalid_o (inst_rvalid_o),
        .inst_rdata_o  (inst_rdata_o),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_addr_i   (data_addr_i),
        .data_sel_i    (data_sel_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .mem_ce_o      (mem_ce_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_sel_o     (mem_sel_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .stall_req_o   (stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical single-port memory driven by the DUT; read data appears WAIT+1 cycles after the strobe.
    logic [DW-1:0] phys_mem [MEMW];
    logic [DW-1:0] rd_pipe  [16];
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (mem_ce_o && mem_we_o) begin
            w = phys_mem[mem_addr_o[9:2]];
            for (int b = 0; b < SW; b++)
                if (mem_sel_o[b]) w[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
            phys_mem[mem_addr_o[9:2]] <= w;
        end
        rd_pipe[0] <= (mem_ce_o && !mem_we_o) ? phys_mem[mem_addr_o[9:2]] : '0;
        for (int k = 1; k < 16; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata_i = rd_pipe[WAIT];

    // Reference model: expected memory image and pending responses with due cycle.
    typedef struct {
        bit            is_data;
        logic [DW-1:0] rdata;
        int            due;
    } resp_t;

    logic [DW-1:0] ref_mem [MEMW];
    resp_t         pend [$];
    int            cyc;
    int            free_at;
    bit            last_data;
    bit            mg_i;
    bit            mg_d;
    int            total;
    int            bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_inst_gnt"},    64'(inst_gnt_o),    64'd0);
        chk({tag, "_inst_rvalid"}, 64'(inst_rvalid_o), 64'd0);
        chk({tag, "_inst_rdata"},  64'(inst_rdata_o),  64'd0);
        chk({tag, "_data_gnt"},    64'(data_gnt_o),    64'd0);
        chk({tag, "_data_rvalid"}, 64'(data_rvalid_o), 64'd0);
        chk({tag, "_data_rdata"},  64'(data_rdata_o),  64'd0);
        chk({tag, "_mem_ce"},      64'(mem_ce_o),      64'd0);
        chk({tag, "_mem_we"},      64'(mem_we_o),      64'd0);
        chk({tag, "_mem_addr"},    64'(mem_addr_o),    64'd0);
        chk({tag, "_mem_sel"},     64'(mem_sel_o),     64'd0);
        chk({tag, "_mem_wdata"},   64'(mem_wdata_o),   64'd0);
        chk({tag, "_stall"},       64'(stall_req_o),   64'd0);
    endtask

    // One clock cycle: compare all outputs with the model at the falling edge,
    // advance the model, then move to just after the next rising edge.
    task automatic cycle_check();
        logic          eg_i, eg_d, win, tie_data, erv_i, erv_d;
        logic [DW-1:0] erd_i, erd_d, e_wd, w;
        logic [AW-1:0] e_addr;
        logic [SW-1:0] e_sel;
        resp_t         r;
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        tie_data = !last_data;
`else
        tie_data = 1'b1;
`endif
        win   = (cyc >= free_at);
        eg_d  = win && data_req_i && (!inst_req_i || tie_data);
        eg_i  = win && inst_req_i && !eg_d;
        erv_i = 1'b0; erv_d = 1'b0; erd_i = '0; erd_d = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].is_data) begin erv_d = 1'b1; erd_d = pend[0].rdata; end
            else                 begin erv_i = 1'b1; erd_i = pend[0].rdata; end
            void'(pend.pop_front());
        end
        e_addr = eg_d ? data_addr_i  : (eg_i ? inst_addr_i : '0);
        e_sel  = eg_d ? data_sel_i   : (eg_i ? '1 : '0);
        e_wd   = eg_d ? data_wdata_i : '0;

        chk("inst_gnt",    64'(inst_gnt_o),    64'(eg_i));
        chk("data_gnt",    64'(data_gnt_o),    64'(eg_d));
        chk("inst_rvalid", 64'(inst_rvalid_o), 64'(erv_i));
        chk("data_rvalid", 64'(data_rvalid_o), 64'(erv_d));
        chk("inst_rdata",  64'(inst_rdata_o),  64'(erd_i));
        chk("data_rdata",  64'(data_rdata_o),  64'(erd_d));
        chk("mem_ce",      64'(mem_ce_o),      64'(eg_i || eg_d));
        chk("mem_we",      64'(mem_we_o),      64'(eg_d && data_we_i));
        chk("mem_addr",    64'(mem_addr_o),    64'(e_addr));
        chk("mem_sel",     64'(mem_sel_o),     64'(e_sel));
        chk("mem_wdata",   64'(mem_wdata_o),   64'(e_wd));
        chk("stall",       64'(stall_req_o),
            64'((inst_req_i && !eg_i) || (data_req_i && !eg_d) || !win));

        if (eg_i || eg_d) begin
            r.is_data = eg_d;
            r.due     = cyc + int'(WAIT) + 1;
            if (eg_d && data_we_i) begin
                w = ref_mem[data_addr_i[9:2]];
                for (int b = 0; b < SW; b++)
                    if (data_sel_i[b]) w[b*8 +: 8] = data_wdata_i[b*8 +: 8];
                ref_mem[data_addr_i[9:2]] = w;
                r.rdata = '0;
            end else begin
                r.rdata = ref_mem[e_addr[9:2]];
            end
            pend.push_back(r);
            free_at   = r.due;
            last_data = eg_d;
        end
        mg_i = eg_i;
        mg_d = eg_d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Serve current requests (dropping each once granted), then drain responses.
    task automatic run_until_idle();
        int budget;
        budget = 50;
        while ((inst_req_i || data_req_i) && budget > 0) begin
            cycle_check();
            if (mg_i) inst_req_i = 1'b0;
            if (mg_d) data_req_i = 1'b0;
            budget--;
        end
        chk("serve_budget", 64'(budget > 0), 64'd1);
        for (int i = 0; i < int'(WAIT) + 2; i++) cycle_check();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk_all_zero("rst_async");
        pend.delete();
        free_at   = 0;
        last_data = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        chk_all_zero("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        int n;
        total = 0; bad = 0; cyc = 0; free_at = 0; last_data = 1'b0;
        mg_i = 1'b0; mg_d = 1'b0;
        for (int i = 0; i < MEMW; i++) begin
            ref_mem[i]  = (i < 64) ? (32'h01010101 * i) ^ 32'hA5000000 : '0;
            phys_mem[i] = ref_mem[i];
        end
        ref_mem[1]  = 32'h34011100;
        phys_mem[1] = 32'h34011100;
        for (int k = 0; k < 16; k++) rd_pipe[k] = '0;

        // Reset with both requests asserted: all outputs must stay 0.
        rst = 1'b0;
        inst_req_i = 1'b1; inst_addr_i = 32'h4;
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h8;
        data_sel_i = 4'hF; data_wdata_i = 32'h12345678;
        @(posedge clk);
        #1;
        chk_all_zero("rst_init");
        @(posedge clk);
        #1;
        inst_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
        rst = 1'b1;

        // Single fetch of word 1.
        inst_req_i = 1'b1; inst_addr_i = 32'h4;
        run_until_idle();

        // Reset while a fetch is outstanding; the old response must never appear.
        inst_req_i = 1'b1; inst_addr_i = 32'h8;
        cycle_check();
        inst_addr_i = 32'h10;
        do_reset();
        run_until_idle();

        // Contention: data load and fetch in the same cycle.
        inst_req_i = 1'b1; inst_addr_i = 32'h20;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h100; data_sel_i = 4'hF;
        run_until_idle();

        // Partial store then readback.
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h200;
        data_sel_i = 4'b0011; data_wdata_i = 32'hDEADBEEF;
        run_until_idle();
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h200;
        data_sel_i = 4'hF; data_wdata_i = '0;
        run_until_idle();

        // Continuous fetches: one grant per WAIT+1 cycles.
        n = 0;
        inst_req_i = 1'b1; inst_addr_i = 32'h0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            cycle_check();
            if (mg_i) begin n++; inst_addr_i = inst_addr_i + 32'h4; end
        end
        inst_req_i = 1'b0;
        chk("cont_fetch_grants", 64'(n), 64'd4);
        run_until_idle();

        // Both ports requesting continuously for six grants.
        n = 0;
        inst_req_i = 1'b1; inst_addr_i = 32'h40;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h80; data_sel_i = 4'hF;
        for (int i = 0; i < 60 && n < 6; i++) begin
            cycle_check();
            if (mg_i) begin n++; inst_addr_i = inst_addr_i + 32'h4; end
            if (mg_d) begin n++; data_addr_i = data_addr_i + 32'h4; end
        end
        inst_req_i = 1'b0; data_req_i = 1'b0;
        chk("both_grants", 64'(n), 64'd6);
        run_until_idle();

        // Random traffic obeying the hold-until-grant rule.
        for (int i = 0; i < 500; i++) begin
            cycle_check();
            if (!inst_req_i || mg_i) begin
                inst_req_i  = ($urandom_range(0, 2) != 0);
                inst_addr_i = $urandom_range(0, MEMW - 1) << 2;
            end
            if (!data_req_i || mg_d) begin
                data_req_i   = ($urandom_range(0, 2) != 0);
                data_we_i    = $urandom_range(0, 1) == 1;
                data_addr_i  = $urandom_range(0, MEMW - 1) << 2;
                data_sel_i   = 4'($urandom_range(1, 15));
                data_wdata_i = $urandom;
            end
        end
        run_until_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port and the CPU data (load/store) port, replacing the dedicated instruction-ROM hookup in the minimal SOPC.
- Handles req/gnt arbitration, fixed-latency wait-state sequencing and response steering.
- Raises a stall request to the pipeline controller while either port is waiting for service.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data word width.
- WAIT_CYCLES, 0, extra memory latency beyond one cycle; legal range 0..15.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst_req_i  in  1  fetch request.
- inst_addr_i  in  ADDR_W  fetch address.
- inst_gnt_o  out  1  fetch request accepted this cycle.
- inst_rvalid_o  out  1  fetch data valid.
- inst_rdata_o  out  DATA_W  fetched instruction.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  1 = store.
- data_addr_i  in  ADDR_W  load/store address.
- data_sel_i  in  DATA_W/8  byte enables.
- data_wdata_i  in  DATA_W  store data.
- data_gnt_o  out  1  load/store request accepted.
- data_rvalid_o  out  1  load data valid, or store acknowledge.
- data_rdata_o  out  DATA_W  load data (0 on store acknowledge).
- mem_ce_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_sel_o  out  DATA_W/8  memory byte enables.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid WAIT_CYCLES+1 cycles after the strobe.
- stall_req_o  out  1  stall request to the pipeline controller.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; wait counter, owner register and round-robin pointer clear to 0.
  - Every output is 0.
  - Any outstanding access is dropped; no rvalid is ever issued for it.
- States:
  - IDLE: no access outstanding.
  - BUSY: one access outstanding; the owner register (INST/DATA) and counter cnt are valid.
- Grant window: IDLE, or the BUSY cycle with cnt==0 (the completion cycle), which allows back-to-back accesses.
- Arbitration in a grant window:
  - Exactly one gnt is asserted combinationally.
  - Data wins over inst when both request (default fixed priority).
  - The granted request's fields drive mem_* in the same cycle with mem_ce_o=1; mem_we_o=data_we_i for data and 0 for inst; mem_sel_o is all-ones for inst.
  - Next state is BUSY; cnt loads WAIT_CYCLES; owner loads the granted port.
- Outside a grant window: gnt=0 and mem_ce_o=0.
- mem_addr_o, mem_sel_o and mem_wdata_o are 0 whenever mem_ce_o=0.
- BUSY:
  - cnt decrements each cycle while cnt!=0.
  - In the cycle with cnt==0, the owner's rvalid_o=1 and rdata_o = mem_rdata_i (combinational pass-through; 0 for a store acknowledge).
  - If nothing is granted in that same cycle, the next state is IDLE.
- Latency: gnt in cycle T gives rvalid in cycle T+1+WAIT_CYCLES. Peak throughput is one access per WAIT_CYCLES+1 cycles.
- Requester rules:
  - req and all request fields stay stable until gnt.
  - req may drop or change the cycle after gnt.
  - A requester may re-request while its own response is pending; it is served in order.
- stall_req_o = (inst_req_i & ~inst_gnt_o) | (data_req_i & ~data_gnt_o) | (state==BUSY & cnt!=0).
- Simultaneous response and new grant to the same port is legal: rvalid belongs to the old access, gnt to the new one.
- When only one port requests, it is granted regardless of priority or pointer.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit pointer records the last granted port.
  - On a simultaneous request, the port not granted last wins.
  - The pointer updates on every grant and resets to "inst last", so data wins the first tie.
- Undefined: fixed data-over-inst priority; no pointer flop exists.

Decomposition:
- Shared defines include gains:
  - `ArbIdle` and `ArbBusy` state encodings.
  - `OwnerInst` and `OwnerData` encodings.
  - Default `ArbWaitCycles`.
- The existing `InstAddrBus` and `InstBus` widths are reused.
- Natural sub-module: arb_wait_cnt.
  - Loadable down-counter.
  - Load/enable inputs, zero flag output.
  - Async active-low reset.

Test Plan:
- Reset mid-access: WAIT_CYCLES=3; inst granted at cycle 5; rst low at cycle 6 -> all outputs 0 immediately; no inst_rvalid_o afterwards; after release, a new fetch to 0x00000010 returns mem contents at T+4.
- Single fetch: WAIT_CYCLES=0; inst_req_i=1 with addr 0x00000004 and mem[1]=0x34011100 -> inst_gnt_o and mem_ce_o in cycle T; inst_rvalid_o=1 with 0x34011100 in T+1; stall_req_o=0 throughout.
- Contention, fixed priority: both requests in cycle T; data is a load from 0x100 -> data_gnt_o=1 and inst_gnt_o=0 in T; stall_req_o=1 in T; inst granted in T+1 (back-to-back); data_rvalid_o in T+1; inst_rvalid_o in T+2.
- Store: data_we_i=1, sel=4'b0011, wdata=0xDEADBEEF, addr 0x200 -> mem_we_o=1 and mem_sel_o=4'b0011 in the grant cycle; data_rvalid_o with data_rdata_o=0 after WAIT_CYCLES+1; a following read of 0x200 returns 0x0000BEEF (memory was zero).
- Wait states: WAIT_CYCLES=2; continuous fetches -> grants every 3rd cycle; rvalid exactly 3 cycles after each grant; stall_req_o high between grants.
- ARB_ROUND_ROBIN_EN defined: both ports request continuously for 6 grants -> order data, inst, data, inst, data, inst.
